// File: rtl/pixel_unpack_stream.sv
// Serialises 32-bit words of four packed grey pixels into one 8-bit pixel per cycle,
// tracking the frame position and dropping padding lanes after a frame's last pixel.
module pixel_unpack_stream #(
    parameter int unsigned FRAME_PIXELS = 1024,
    parameter int unsigned IDX_W        = 24
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_pix,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [IDX_W-1:0] out_index
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_PIXELS - 1);

    logic [31:0]      wbuf_q, wbuf_d;
    logic [1:0]       lane_q, lane_d;
    logic             full_q, full_d;
    logic [IDX_W-1:0] idx_q,  idx_d;

    logic at_last, fire, done, accept;

    assign at_last   = (idx_q == LAST_IDX);
    assign out_valid = full_q;
    assign out_pix   = wbuf_q[{lane_q, 3'b000} +: 8];
    assign out_last  = full_q & at_last;
    assign out_index = idx_q;

    // A word finishes on its fourth lane or early on the frame's last pixel,
    // which frees the buffer for a refill in the same cycle.
    assign fire     = full_q & out_ready;
    assign done     = fire & ((lane_q == 2'd3) | at_last);
    assign in_ready = ~full_q | done;
    assign accept   = in_valid & in_ready;

    always_comb begin
        wbuf_d = wbuf_q;
        lane_d = lane_q;
        full_d = full_q;
        idx_d  = idx_q;
        if (accept) begin
            wbuf_d = in_data;
            full_d = 1'b1;
            lane_d = 2'd0;
        end else if (fire) begin
            if (done) begin
                full_d = 1'b0;
                lane_d = 2'd0;
            end else begin
                lane_d = lane_q + 2'd1;
            end
        end
        if (fire) begin
            idx_d = at_last ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wbuf_q <= '0;
            lane_q <= '0;
            full_q <= 1'b0;
            idx_q  <= '0;
        end else begin
            wbuf_q <= wbuf_d;
            lane_q <= lane_d;
            full_q <= full_d;
            idx_q  <= idx_d;
        end
    end
endmodule

// File: tb/tb_pixel_unpack_stream.sv
// Bench for pixel_unpack_stream: four instances (FRAME_PIXELS 8, 6, 1, 1023) checked each
// cycle against a per-word pixel queue model, plus hand-computed literal sequences.
module tb_pixel_unpack_stream;
    localparam int NI = 4;

    typedef struct packed {
        logic [7:0]  pix;
        logic [23:0] idx;
        logic        last;
    } pix_t;

    typedef struct {
        logic [7:0]  pix;
        logic [23:0] idx;
        logic        last;
        logic        rdy;
        int          cyc;
    } ev_t;

    logic        clock;
    logic        resetn;
    logic [31:0] in_data   [NI];
    logic        in_valid  [NI];
    logic        in_ready  [NI];
    logic [7:0]  out_pix   [NI];
    logic        out_valid [NI];
    logic        out_ready [NI];
    logic        out_last  [NI];
    logic [23:0] out_index [NI];

    int   mode    [NI];   // 0 always ready, 1 toggle, 2 random, 3 manual
    logic man_rdy [NI];
    logic gen_rdy [NI];

    pix_t q  [NI][$];
    ev_t  lg [NI][$];
    int   m_idx [NI];
    int   cyc;
    int   n_tests, n_fail;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned FPG = (g == 0) ? 8 : (g == 1) ? 6 : (g == 2) ? 1 : 1023;
        pixel_unpack_stream #(.FRAME_PIXELS(FPG), .IDX_W(24)) u_dut (
            .clock    (clock),
            .resetn   (resetn),
            .in_data  (in_data[g]),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .out_pix  (out_pix[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_last (out_last[g]),
            .out_index(out_index[g])
        );
    end

    function automatic int fp_of(input int i);
        case (i)
            0:       return 8;
            1:       return 6;
            2:       return 1;
            default: return 1023;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        #1;
        for (int i = 0; i < NI; i++) begin
            case (mode[i])
                1:       gen_rdy[i] = ~gen_rdy[i];
                2:       gen_rdy[i] = ($urandom_range(0, 3) != 0);
                default: gen_rdy[i] = 1'b1;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NI; i++) out_ready[i] = (mode[i] == 3) ? man_rdy[i] : gen_rdy[i];
    end

    // Model: the queue holds exactly the pixels still to come from the buffered word.
    always @(negedge clock) begin
        bit ev, er;
        for (int i = 0; i < NI; i++) begin
            if (!resetn) begin
                q[i].delete();
                m_idx[i] = 0;
                chk("rst_out_valid", 32'(out_valid[i]), 0);
                chk("rst_out_pix",   32'(out_pix[i]),   0);
                chk("rst_out_last",  32'(out_last[i]),  0);
                chk("rst_out_index", 32'(out_index[i]), 0);
                chk("rst_in_ready",  32'(in_ready[i]),  1);
            end else begin
                ev = (q[i].size() != 0);
                er = !ev || (out_ready[i] && q[i].size() == 1);
                chk("out_valid", 32'(out_valid[i]), 32'(ev));
                chk("in_ready",  32'(in_ready[i]),  32'(er));
                if (ev) begin
                    chk("out_pix",   32'(out_pix[i]),   32'(q[i][0].pix));
                    chk("out_index", 32'(out_index[i]), 32'(q[i][0].idx));
                    chk("out_last",  32'(out_last[i]),  32'(q[i][0].last));
                    if (out_ready[i]) begin
                        lg[i].push_back('{out_pix[i], out_index[i], out_last[i], in_ready[i], cyc});
                        void'(q[i].pop_front());
                    end
                end
                if (in_valid[i] && er) begin
                    for (int l = 0; l < 4; l++) begin
                        pix_t p;
                        p.pix  = in_data[i][8*l +: 8];
                        p.idx  = 24'(m_idx[i]);
                        p.last = (m_idx[i] == fp_of(i) - 1);
                        q[i].push_back(p);
                        if (p.last) begin
                            m_idx[i] = 0;
                            break;
                        end
                        m_idx[i]++;
                    end
                end
            end
        end
    end

    task automatic send(input int i, input logic [31:0] w, output int acc_cyc);
        bit acc;
        in_data[i]  = w;
        in_valid[i] = 1'b1;
        acc = 0;
        acc_cyc = -1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clock);
            acc = in_ready[i];
            if (acc) acc_cyc = cyc;
            @(posedge clock);
            #1;
            if (acc) break;
        end
        if (!acc) chk("send_timeout", 32'(0), 32'(1));
    endtask

    task automatic drain(input int i);
        bit idle;
        idle = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clock);
            if (!out_valid[i]) begin
                idle = 1;
                break;
            end
        end
        if (!idle) chk("drain_timeout", 32'(0), 32'(1));
        @(posedge clock);
        #1;
    endtask

    task automatic ev_chk(input int i, input int k, input logic [7:0] p, input int idx, input bit last);
        if (k >= lg[i].size()) begin
            chk("log_length", 32'(lg[i].size()), 32'(k + 1));
        end else begin
            chk("seq_pix",   32'(lg[i][k].pix),  32'(p));
            chk("seq_index", 32'(lg[i][k].idx),  32'(idx));
            chk("seq_last",  32'(lg[i][k].last), 32'(last));
        end
    endtask

    initial begin
        int a0, a1;
        logic [7:0] e8  [8];
        logic [7:0] e10 [10];
        int         i10 [10];
        e8  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        e10 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h99, 8'hAA, 8'hBB, 8'hCC};
        i10 = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3};
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        resetn  = 1'b0;
        for (int i = 0; i < NI; i++) begin
            in_data[i]  = '0;
            in_valid[i] = 1'b0;
            mode[i]     = 0;
            man_rdy[i]  = 1'b1;
            gen_rdy[i]  = 1'b1;
        end
        repeat (3) @(posedge clock);
        #3 resetn = 1'b1;
        @(posedge clock);
        #1;

        // FRAME_PIXELS=8, always ready: eight back-to-back pixels one cycle after accept
        lg[0].delete();
        send(0, 32'h44332211, a0);
        send(0, 32'h88776655, a1);
        in_valid[0] = 1'b0;
        drain(0);
        chk("t1_count", 32'(lg[0].size()), 8);
        for (int k = 0; k < 8; k++) begin
            ev_chk(0, k, e8[k], k, k == 7);
            if (k < lg[0].size()) chk("t1_cycle", 32'(lg[0][k].cyc), 32'(a0 + 1 + k));
        end
        if (lg[0].size() > 3) chk("t1_ready_on_44", 32'(lg[0][3].rdy), 1);

        // same stream, out_ready toggling
        mode[0] = 1;
        lg[0].delete();
        send(0, 32'h44332211, a0);
        send(0, 32'h88776655, a1);
        in_valid[0] = 1'b0;
        drain(0);
        mode[0] = 0;
        chk("t2_count", 32'(lg[0].size()), 8);
        for (int k = 0; k < 8; k++) ev_chk(0, k, e8[k], k, k == 7);

        // FRAME_PIXELS=6: lanes 77/88 dropped, next word starts a new frame
        lg[1].delete();
        send(1, 32'h44332211, a0);
        send(1, 32'h88776655, a1);
        send(1, 32'hCCBBAA99, a1);
        in_valid[1] = 1'b0;
        drain(1);
        chk("t3_count", 32'(lg[1].size()), 10);
        for (int k = 0; k < 10; k++) ev_chk(1, k, e10[k], i10[k], k == 5);

        // FRAME_PIXELS=1: one pixel per word, each the frame's last
        lg[2].delete();
        send(2, 32'hDDCCBBAA, a0);
        send(2, 32'h04030201, a1);
        in_valid[2] = 1'b0;
        drain(2);
        chk("t4_count", 32'(lg[2].size()), 2);
        ev_chk(2, 0, 8'hAA, 0, 1'b1);
        ev_chk(2, 1, 8'h01, 0, 1'b1);
        chk("t4_accept_gap", 32'(a1 - a0), 1);

        // asynchronous reset mid-word
        mode[0]    = 3;
        man_rdy[0] = 1'b0;
        send(0, 32'h44332211, a0);
        man_rdy[0] = 1'b1;
        send(0, 32'h88776655, a1);
        in_valid[0] = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1 man_rdy[0] = 1'b0;
        chk("t5_pre_pix", 32'(out_pix[0]), 32'h77);
        #2 resetn = 1'b0;
        #1;
        chk("t5_async_valid", 32'(out_valid[0]), 0);
        chk("t5_async_index", 32'(out_index[0]), 0);
        chk("t5_async_ready", 32'(in_ready[0]), 1);
        repeat (2) @(posedge clock);
        #3 resetn = 1'b1;
        @(posedge clock);
        #1 man_rdy[0] = 1'b1;
        lg[0].delete();
        send(0, 32'hA0B0C0D0, a0);
        in_valid[0] = 1'b0;
        drain(0);
        mode[0] = 0;
        chk("t5_count", 32'(lg[0].size()), 4);
        ev_chk(0, 0, 8'hD0, 0, 1'b0);
        ev_chk(0, 3, 8'hA0, 3, 1'b0);

        // FRAME_PIXELS=1023, random handshakes on both sides
        mode[3] = 2;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid[3] = 1'b0;
                @(posedge clock);
                #1;
            end
            send(3, $urandom, a0);
        end
        in_valid[3] = 1'b0;
        drain(3);

        // both sides always ready: one pixel on every cycle
        mode[3] = 0;
        lg[3].delete();
        for (int n = 0; n < 1000; n++) send(3, $urandom, a0);
        in_valid[3] = 1'b0;
        drain(3);
        chk("t6_min_pixels", 32'(lg[3].size() >= 3990), 1);
        if (lg[3].size() > 0)
            chk("t6_throughput", 32'(lg[3][lg[3].size()-1].cyc - lg[3][0].cyc + 1), 32'(lg[3].size()));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
